// File: rtl/tag_rsdp_seq.sv
// Row sequencer around a mod-127 inner-product unit: 3 cycles per row minimum, row accepted only in LOAD,
// element held on u_* until consumer ready. Optional job checksum with `TAG_RSDP_SEQ_SUM_EN.
package tag_rsdp_pkg;
  // 7-bit one's-complement add with end-around carry; 0x00 and 0x7F both mean zero.
  function automatic logic [6:0] oc_add7(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7] ? s[6:0] + 7'd1 : s[6:0];
  endfunction
endpackage

module tag_rsdp_unroll (
  input  logic         i_clk,
  input  logic         i_ldy,
  input  logic         i_ldb,
  input  logic         i_innerprod,
  input  logic [135:0] i_y,
  input  logic [237:0] i_b,
  output logic [6:0]   o_u
);
  logic [135:0] r_y;
  logic [237:0] r_b;
  logic [6:0]   r_u;
  logic [6:0]   w_acc;
  logic [3:0]   w_nib;
  logic [13:0]  w_dbl;
  logic [6:0]   w_term;

  // Rotate-left by r is multiply by 2^r mod 127; inversion is negation.
  always_comb begin
    w_acc  = '0;
    w_nib  = '0;
    w_dbl  = '0;
    w_term = '0;
    for (int i = 0; i < 34; i++) begin
      w_nib  = r_y[4*i +: 4];
      w_dbl  = {r_b[7*i +: 7], r_b[7*i +: 7]};
      w_term = 7'(w_dbl >> (3'd7 - w_nib[2:0])) ^ {7{w_nib[3]}};
      w_acc  = tag_rsdp_pkg::oc_add7(w_acc, w_term);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ldy)       r_y <= i_y;
    if (i_ldb)       r_b <= i_b;
    if (i_innerprod) r_u <= w_acc;
  end

  assign o_u = r_u;
endmodule

module tag_rsdp_seq #(
  parameter int NROWS = 64,
  parameter int IDX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [135:0]     i_y_in,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [237:0]     i_b_data,
  output logic             o_u_valid,
  input  logic             i_u_ready,
  output logic [6:0]       o_u_data,
  output logic [IDX_W-1:0] o_u_idx,
  output logic             o_busy,
  output logic             o_done
`ifdef TAG_RSDP_SEQ_SUM_EN
  ,
  output logic [6:0]       o_sum_out
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PROD = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROWS - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             w_ldy;
  logic             w_ldb;
  logic             w_innerprod;
  logic             w_u_hs;
  logic             w_abort;

  assign o_b_ready   = (r_state == S_LOAD) & ~i_abort;
  assign o_u_valid   = (r_state == S_OUT);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_FIN);
  assign o_u_idx     = r_idx;
  assign w_ldy       = (r_state == S_IDLE) & i_start;
  assign w_ldb       = o_b_ready & i_b_valid;
  assign w_innerprod = (r_state == S_PROD);
  assign w_u_hs      = o_u_valid & i_u_ready;
  assign w_abort     = i_abort & o_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_ldb) w_state_nxt = S_PROD;
      S_PROD:  w_state_nxt = S_OUT;
      S_OUT:   if (i_u_ready) w_state_nxt = (r_idx == LAST_IDX) ? S_FIN : S_LOAD;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ldy || w_abort)
        r_idx <= '0;
      else if (w_u_hs && r_idx != LAST_IDX)
        r_idx <= r_idx + IDX_W'(1);
    end
  end

  tag_rsdp_unroll u_unit (
    .i_clk       (i_clk),
    .i_ldy       (w_ldy),
    .i_ldb       (w_ldb),
    .i_innerprod (w_innerprod),
    .i_y         (i_y_in),
    .i_b         (i_b_data),
    .o_u         (o_u_data)
  );

`ifdef TAG_RSDP_SEQ_SUM_EN
  logic [6:0] r_sum;

  // A delivered element that coincides with abort is still dropped from the sum.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_ldy || w_abort)
      r_sum <= '0;
    else if (w_u_hs)
      r_sum <= tag_rsdp_pkg::oc_add7(r_sum, o_u_data);
  end

  assign o_sum_out = r_sum;
`else
  // Without the checksum the sequencer carries no accumulator state.
`endif
endmodule

// File: tb/tb_tag_rsdp_seq.sv
// Directed bench: a one-row instance for arithmetic/timing vectors, a four-row instance for
// stalls, abort, reset and the optional checksum.
module tb_tag_rsdp_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start1, start4, abort, b_valid, u_ready;
  logic [135:0] y_in;
  logic [237:0] b_data;
  logic         b_ready1, u_valid1, busy1, done1;
  logic         b_ready4, u_valid4, busy4, done4;
  logic [6:0]   u_data1, u_data4;
  logic [7:0]   u_idx1, u_idx4;
`ifdef TAG_RSDP_SEQ_SUM_EN
  logic [6:0]   sum1, sum4;
`endif

  int n_run = 0;
  int n_fail = 0;
  int n_ldy = 0;
  int n_ldb = 0;
  int n_ip = 0;

  tag_rsdp_seq #(.NROWS(1), .IDX_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort), .i_y_in(y_in),
    .i_b_valid(b_valid), .o_b_ready(b_ready1), .i_b_data(b_data), .o_u_valid(u_valid1),
    .i_u_ready(u_ready), .o_u_data(u_data1), .o_u_idx(u_idx1), .o_busy(busy1), .o_done(done1)
`ifdef TAG_RSDP_SEQ_SUM_EN
    , .o_sum_out(sum1)
`endif
  );

  tag_rsdp_seq #(.NROWS(4), .IDX_W(8)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_abort(abort), .i_y_in(y_in),
    .i_b_valid(b_valid), .o_b_ready(b_ready4), .i_b_data(b_data), .o_u_valid(u_valid4),
    .i_u_ready(u_ready), .o_u_data(u_data4), .o_u_idx(u_idx4), .o_busy(busy4), .o_done(done4)
`ifdef TAG_RSDP_SEQ_SUM_EN
    , .o_sum_out(sum4)
`endif
  );

  always @(posedge clk) begin
    if (dut1.w_ldy)       n_ldy <= n_ldy + 1;
    if (dut1.w_ldb)       n_ldb <= n_ldb + 1;
    if (dut1.w_innerprod) n_ip  <= n_ip + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  // Full one-row job on dut1 with b_valid and u_ready held high.
  task automatic job1(input logic [135:0] y, input logic [237:0] b, input logic [6:0] eu,
                      input string tag);
    y_in = y;
    b_data = b;
    start1 = 1'b1;
    #1 chk({tag, " idle busy"}, 32'(busy1), 0);
    cyc; start1 = 1'b0;
    #1 chk({tag, " load b_ready"}, 32'(b_ready1), 1);
    chk({tag, " load u_valid"}, 32'(u_valid1), 0);
    cyc;
    #1 chk({tag, " prod u_valid"}, 32'(u_valid1), 0);
    chk({tag, " prod b_ready"}, 32'(b_ready1), 0);
    cyc;
    #1 chk({tag, " out u_valid"}, 32'(u_valid1), 1);
    chk({tag, " out u_data"}, 32'(u_data1), 32'(eu));
    chk({tag, " out u_idx"}, 32'(u_idx1), 0);
    cyc;
    #1 chk({tag, " fin done"}, 32'(done1), 1);
    chk({tag, " fin u_valid"}, 32'(u_valid1), 0);
    cyc;
    #1 chk({tag, " idle done"}, 32'(done1), 0);
    chk({tag, " idle busy"}, 32'(busy1), 0);
  endtask

  // Entered in LOAD with the row on b_data; leaves in OUT before the handshake edge.
  task automatic row4(input logic [6:0] eu, input logic [7:0] ei, input logic [237:0] nb);
    #1 chk("row4 load b_ready", 32'(b_ready4), 1);
    cyc; b_data = nb;
    #1 chk("row4 prod b_ready", 32'(b_ready4), 0);
    chk("row4 prod u_valid", 32'(u_valid4), 0);
    cyc;
    #1 chk("row4 out u_valid", 32'(u_valid4), 1);
    chk("row4 out u_data", 32'(u_data4), 32'(eu));
    chk("row4 out u_idx", 32'(u_idx4), 32'(ei));
    chk("row4 out done", 32'(done4), 0);
  endtask

  initial begin
    logic [135:0] y;
    logic [237:0] b, b1, b2, b3;

    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
    b_valid = 1'b1; u_ready = 1'b1; y_in = '0; b_data = '0;
    cyc; cyc;
    #1 chk("rst busy1", 32'(busy1), 0);
    chk("rst done1", 32'(done1), 0);
    chk("rst b_ready1", 32'(b_ready1), 0);
    chk("rst u_valid4", 32'(u_valid4), 0);
    chk("rst u_idx4", 32'(u_idx4), 0);
    chk("rst busy4", 32'(busy4), 0);
`ifdef TAG_RSDP_SEQ_SUM_EN
    chk("rst sum4", 32'(sum4), 0);
`endif
    rst_n = 1'b1;
    cyc;

    // Arithmetic and timing vectors on the one-row instance.
    job1('0, '0, 7'h00, "zero");
    chk("ldy pulses", 32'(n_ldy), 1);
    chk("ldb pulses", 32'(n_ldb), 1);
    chk("innerprod pulses", 32'(n_ip), 1);
    y = '0; b = '0; b[6:0] = 7'h05;
    job1(y, b, 7'h05, "b0=5");
    y = '0; y[3:0] = 4'h1; b = '0; b[6:0] = 7'h01;
    job1(y, b, 7'h02, "rot1");
    y = '0; y[3:0] = 4'h8; b = '0;
    job1(y, b, 7'h7F, "inv0");
    y = '0; y[3:0] = 4'h3; b = '0; b[6:0] = 7'h01; b[13:7] = 7'h02;
    job1(y, b, 7'h0A, "rot3+b1");
    y = '0; y[3:0] = 4'h8; b = '0; b[6:0] = 7'h05; b[13:7] = 7'h05;
    job1(y, b, 7'h7F, "negsum");
    y = '0; y[3:0] = 4'h7; b = '0; b[6:0] = 7'h41;
    job1(y, b, 7'h41, "rot7");
    y = '0; b = '0; b[6:0] = 7'h7E; b[13:7] = 7'h03;
    job1(y, b, 7'h02, "carry");
    y = '0; y[3:0] = 4'h2; b = '0; b[6:0] = 7'h60;
    job1(y, b, 7'h03, "rotwrap");
    y = '0; y[135:132] = 4'h9; b = '0; b[237:231] = 7'h01;
    job1(y, b, 7'h7D, "elem33");

    // Four-row job with a 3-cycle consumer stall on row 1.
    y_in = '0;
    b = '0; b[6:0] = 7'h7F; b1 = '0; b1[6:0] = 7'h01;
    b2 = '0; b2[6:0] = 7'h10; b3 = '0; b3[6:0] = 7'h20;
    b_data = b; start4 = 1'b1;
    cyc; start4 = 1'b0;
    row4(7'h7F, 8'd0, b1);
    cyc;
    row4(7'h01, 8'd1, b2);
    u_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall u_valid", 32'(u_valid4), 1);
      chk("stall u_data", 32'(u_data4), 32'h01);
      chk("stall u_idx", 32'(u_idx4), 1);
      chk("stall b_ready", 32'(b_ready4), 0);
      chk("stall done", 32'(done4), 0);
      cyc;
    end
    #1 chk("stall end u_idx", 32'(u_idx4), 1);
    u_ready = 1'b1;
    cyc;
    row4(7'h10, 8'd2, b3);
    cyc;
    row4(7'h20, 8'd3, '0);
    cyc;
    #1 chk("job4 fin done", 32'(done4), 1);
`ifdef TAG_RSDP_SEQ_SUM_EN
    chk("job4 sum 7F+01+10+20", 32'(sum4), 32'h31);
`endif
    cyc;
    #1 chk("job4 idle done", 32'(done4), 0);
    chk("job4 idle busy", 32'(busy4), 0);
`ifdef TAG_RSDP_SEQ_SUM_EN
    chk("job4 sum held", 32'(sum4), 32'h31);
`endif

    // Second job: checksum of 0x10, 0x20, 0, 0; start during FIN must be ignored.
    b = '0; b[6:0] = 7'h10; b1 = '0; b1[6:0] = 7'h20;
    b_data = b; start4 = 1'b1;
    cyc; start4 = 1'b0;
    row4(7'h10, 8'd0, b1);
    cyc;
    row4(7'h20, 8'd1, '0);
    cyc;
    row4(7'h00, 8'd2, '0);
    cyc;
    row4(7'h00, 8'd3, '0);
    cyc;
    #1 chk("job5 fin done", 32'(done4), 1);
`ifdef TAG_RSDP_SEQ_SUM_EN
    chk("job5 sum 10+20", 32'(sum4), 32'h30);
`endif
    start4 = 1'b1;
    cyc; start4 = 1'b0;
    #1 chk("start in fin ignored", 32'(busy4), 0);

    // Abort in LOAD of row 1 while a row is offered.
    b = '0; b[6:0] = 7'h05; b1 = '0; b1[6:0] = 7'h06;
    b_data = b; start4 = 1'b1;
    cyc; start4 = 1'b0;
    row4(7'h05, 8'd0, b1);
    cyc;
    abort = 1'b1;
    #1 chk("abort b_ready", 32'(b_ready4), 0);
    chk("abort no ldb", 32'(dut4.w_ldb), 0);
    chk("abort pre u_idx", 32'(u_idx4), 1);
    cyc; abort = 1'b0;
    #1 chk("abort busy", 32'(busy4), 0);
    chk("abort done", 32'(done4), 0);
    chk("abort u_idx", 32'(u_idx4), 0);
`ifdef TAG_RSDP_SEQ_SUM_EN
    chk("abort sum", 32'(sum4), 0);
`endif
    cyc;
    #1 chk("abort stays idle", 32'(busy4), 0);
    chk("abort no late done", 32'(done4), 0);

    // Start and abort together in IDLE, then reset in PROD.
    start4 = 1'b1; abort = 1'b1;
    cyc; start4 = 1'b0; abort = 1'b0;
    #1 chk("start beats abort", 32'(busy4), 1);
    chk("start+abort b_ready", 32'(b_ready4), 1);
    cyc;
    #1 chk("prod before rst", 32'(busy4), 1);
    rst_n = 1'b0;
    cyc;
    #1 chk("rst mid busy", 32'(busy4), 0);
    chk("rst mid u_valid", 32'(u_valid4), 0);
    chk("rst mid u_idx", 32'(u_idx4), 0);
    rst_n = 1'b1;
    cyc;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
